// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine
//   SPI-mode SD command engine: sends a 6-byte command frame, polls for the
//   R1 response and, when asked, a start token followed by a data block and
//   its CRC16. The SPI link is mode 0; sclk half-period is CLK_DIV clk cycles.
//
// Ports
//   clk, reset        sole clock, synchronous active-high reset
//   start             launch command (sampled only in IDLE)
//   cmd_index/arg/crc command fields; frame = 0x40|index, arg MSB first, {crc,1}
//   rd_data_en        expect a data block after a 0x00 R1
//   busy, done        busy from acceptance until the one-cycle done pulse
//   status            {crc_err, token_err, r1_timeout}, valid with done
//   r1                captured R1 byte
//   data_out/valid    payload bytes, one-cycle strobe each
//   spi_*             SPI master pins
//
// Build option
//   SD_CMD_CRC16_CHECK_EN : check CRC16-CCITT (0x1021, init 0) of the payload
//                           against the received CRC; otherwise crc_err = 0.
//
// state      | meaning
// IDLE       | waiting for start, cs_n high
// SEND       | shifting out the 6 command bytes
// WAIT_R1    | polling 0xFF bytes for a byte with bit7 = 0
// WAIT_TOKEN | polling for 0xFE start token or an error token
// READ_DATA  | receiving DATA_BYTES payload bytes
// READ_CRC   | receiving the 2 CRC16 bytes
// FINISH     | one trailing 0xFF byte with cs_n high, then done

module sd_spi_cmd_engine #(
  parameter int DATA_BYTES     = 512,
  parameter int CLK_DIV        = 2,
  parameter int R1_WAIT_MAX    = 8,
  parameter int TOKEN_WAIT_MAX = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        rd_data_en,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [7:0]  r1,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  localparam logic [2:0] IDLE = 3'd0, SEND = 3'd1, WAIT_R1 = 3'd2, WAIT_TOKEN = 3'd3,
                         READ_DATA = 3'd4, READ_CRC = 3'd5, FINISH = 3'd6;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int R1_W  = (R1_WAIT_MAX > 1) ? $clog2(R1_WAIT_MAX) : 1;
  localparam int TOK_W = (TOKEN_WAIT_MAX > 1) ? $clog2(TOKEN_WAIT_MAX) : 1;
  localparam int DAT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic [2:0]       state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, dv_q, dv_d;
  logic [2:0]       status_q, status_d;
  logic [7:0]       r1_q, r1_d, dout_q, dout_d;
  logic             sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             act_q, act_d;
  logic [39:0]      cmd_q, cmd_d;
  logic             rd_en_q, rd_en_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [R1_W-1:0]  r1cnt_q, r1cnt_d;
  logic [TOK_W-1:0] tokcnt_q, tokcnt_d;
  logic [DAT_W-1:0] datcnt_q, datcnt_d;
  logic             byte_end, launch;
  logic [7:0]       tx_byte;
`ifdef SD_CMD_CRC16_CHECK_EN
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       crc_hi_q, crc_hi_d;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction
`endif

  // last falling sclk edge of the current byte; rx_q then holds all 8 bits
  assign byte_end = act_q && (div_q == '0) && sclk_q && (bit_q == 3'd0);

  always_comb begin
    state_d = state_q;  busy_d = busy_q;  done_d = 1'b0;  dv_d = 1'b0;
    status_d = status_q; r1_d = r1_q; dout_d = dout_q;
    sclk_d = sclk_q; mosi_d = mosi_q; cs_n_d = cs_n_q;
    div_d = div_q; bit_d = bit_q; tx_d = tx_q; rx_d = rx_q; act_d = act_q;
    cmd_d = cmd_q; rd_en_d = rd_en_q; cnt_d = cnt_q;
    r1cnt_d = r1cnt_q; tokcnt_d = tokcnt_q; datcnt_d = datcnt_q;
    launch = 1'b0; tx_byte = 8'hFF;
`ifdef SD_CMD_CRC16_CHECK_EN
    crc_d = crc_q; crc_hi_d = crc_hi_q;
`endif

    // bit shifter: sample on rising sclk, shift mosi on falling sclk
    if (act_q) begin
      if (div_q != '0) begin
        div_d = div_q - 1'b1;
      end else begin
        div_d = DIV_W'(CLK_DIV - 1);
        if (!sclk_q) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], spi_miso};
        end else begin
          sclk_d = 1'b0;
          if (bit_q == 3'd0) begin
            act_d = 1'b0;
          end else begin
            bit_d  = bit_q - 1'b1;
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b1};
          end
        end
      end
    end

    case (state_q)
      IDLE: if (start) begin
        busy_d   = 1'b1;
        cs_n_d   = 1'b0;
        status_d = 3'b000;
        r1_d     = 8'hFF;
        rd_en_d  = rd_data_en;
        cmd_d    = {cmd_arg, cmd_crc, 1'b1};
        cnt_d    = 3'd5;
        launch   = 1'b1;
        tx_byte  = {2'b01, cmd_index};
        state_d  = SEND;
      end
      SEND: if (byte_end) begin
        launch = 1'b1;
        if (cnt_q == 3'd0) begin
          r1cnt_d = R1_W'(R1_WAIT_MAX - 1);
          state_d = WAIT_R1;
        end else begin
          tx_byte = cmd_q[39:32];
          cmd_d   = cmd_q << 8;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      WAIT_R1: if (byte_end) begin
        launch = 1'b1;
        if (!rx_q[7]) begin
          r1_d = rx_q;
          if (rx_q != 8'h00 || !rd_en_q) begin
            cs_n_d = 1'b1; state_d = FINISH;
          end else begin
            tokcnt_d = TOK_W'(TOKEN_WAIT_MAX - 1);
            state_d  = WAIT_TOKEN;
          end
        end else if (r1cnt_q == '0) begin
          status_d[0] = 1'b1; cs_n_d = 1'b1; state_d = FINISH;
        end else begin
          r1cnt_d = r1cnt_q - 1'b1;
        end
      end
      WAIT_TOKEN: if (byte_end) begin
        launch = 1'b1;
        if (rx_q == 8'hFE) begin
          datcnt_d = DAT_W'(DATA_BYTES - 1);
          state_d  = READ_DATA;
`ifdef SD_CMD_CRC16_CHECK_EN
          crc_d = 16'h0000;
`endif
        end else if (rx_q[7:4] == 4'h0 || tokcnt_q == '0) begin
          status_d[1] = 1'b1; cs_n_d = 1'b1; state_d = FINISH;
        end else begin
          tokcnt_d = tokcnt_q - 1'b1;
        end
      end
      READ_DATA: if (byte_end) begin
        launch = 1'b1;
        dout_d = rx_q;
        dv_d   = 1'b1;
`ifdef SD_CMD_CRC16_CHECK_EN
        crc_d = crc16_upd(crc_q, rx_q);
`endif
        if (datcnt_q == '0) begin
          cnt_d = 3'd1; state_d = READ_CRC;
        end else begin
          datcnt_d = datcnt_q - 1'b1;
        end
      end
      READ_CRC: if (byte_end) begin
        launch = 1'b1;
        if (cnt_q == 3'd0) begin
`ifdef SD_CMD_CRC16_CHECK_EN
          if ({crc_hi_q, rx_q} != crc_q) status_d[2] = 1'b1;
`endif
          cs_n_d = 1'b1; state_d = FINISH;
        end else begin
          cnt_d = 3'd0;
`ifdef SD_CMD_CRC16_CHECK_EN
          crc_hi_d = rx_q;
`endif
        end
      end
      FINISH: if (byte_end) begin
        done_d = 1'b1; busy_d = 1'b0; state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      tx_d   = tx_byte[6:0];
      mosi_d = tx_byte[7];
      sclk_d = 1'b0;
      div_d  = DIV_W'(CLK_DIV - 1);
      bit_d  = 3'd7;
      act_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;  busy_q <= 1'b0; done_q <= 1'b0; dv_q <= 1'b0;
      status_q <= 3'b000; r1_q <= 8'hFF; dout_q <= 8'h00;
      sclk_q <= 1'b0; mosi_q <= 1'b1; cs_n_q <= 1'b1;
      div_q <= '0; bit_q <= 3'd0; tx_q <= '1; rx_q <= '1; act_q <= 1'b0;
      cmd_q <= '0; rd_en_q <= 1'b0; cnt_q <= 3'd0;
      r1cnt_q <= '0; tokcnt_q <= '0; datcnt_q <= '0;
`ifdef SD_CMD_CRC16_CHECK_EN
      crc_q <= 16'h0000; crc_hi_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;  busy_q <= busy_d; done_q <= done_d; dv_q <= dv_d;
      status_q <= status_d; r1_q <= r1_d; dout_q <= dout_d;
      sclk_q <= sclk_d; mosi_q <= mosi_d; cs_n_q <= cs_n_d;
      div_q <= div_d; bit_q <= bit_d; tx_q <= tx_d; rx_q <= rx_d; act_q <= act_d;
      cmd_q <= cmd_d; rd_en_q <= rd_en_d; cnt_q <= cnt_d;
      r1cnt_q <= r1cnt_d; tokcnt_q <= tokcnt_d; datcnt_q <= datcnt_d;
`ifdef SD_CMD_CRC16_CHECK_EN
      crc_q <= crc_d; crc_hi_q <= crc_hi_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign r1         = r1_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine
//   Bench for sd_spi_cmd_engine with a small SD-card model on the SPI pins.
//   The card replays a prepared byte stream on miso (byte-aligned to the
//   engine's frames from the chip-select fall) and records every mosi byte
//   together with the chip-select level seen while it was clocked.

module tb_sd_spi_cmd_engine;

  localparam int NB   = 4;
  localparam int CDIV = 2;
  localparam int R1W  = 8;
  localparam int TOKW = 16;
`ifdef SD_CMD_CRC16_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0, reset, start, rd_data_en, spi_miso;
  logic [5:0] cmd_index; logic [31:0] cmd_arg; logic [6:0] cmd_crc;
  logic busy, done, data_valid, spi_sclk, spi_mosi, spi_cs_n;
  logic [2:0] status; logic [7:0] r1, data_out;

  always #5 clk = ~clk;

  sd_spi_cmd_engine #(.DATA_BYTES(NB), .CLK_DIV(CDIV), .R1_WAIT_MAX(R1W),
                      .TOKEN_WAIT_MAX(TOKW)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .rd_data_en(rd_data_en), .busy(busy), .done(done),
    .status(status), .r1(r1), .data_out(data_out), .data_valid(data_valid),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n));

  typedef struct {
    logic [5:0] idx; logic [31:0] arg; logic [6:0] crc; logic rd;
    int r1_dly; logic [7:0] r1b; int tok_dly; logic [7:0] tokb; int crc_mode;
    logic [2:0] exp_status; logic [7:0] exp_r1; int exp_nd; int exp_nbytes;
  } vec_t;

  int tests = 0, fails = 0;

  // ---------------- card model ----------------
  logic [7:0] m_stream [64];
  logic [7:0] miso_byte = 8'hFF;
  logic [2:0] m_bit = 3'd0;
  int         m_idx = 0;
  logic [7:0] mosi_log [64];
  logic       cs_log [64];
  int         mo_n = 0, mo_bits = 0;
  logic [7:0] mo_sr = 8'h00;
  logic       cs_prev = 1'b1, sclk_prev = 1'b0;

  function automatic logic [7:0] get_b(input int i);
    return (i < 64) ? m_stream[i] : 8'hFF;
  endfunction

  always @(spi_sclk or spi_cs_n) begin
    if (cs_prev && !spi_cs_n) begin
      m_bit = 3'd0; miso_byte = get_b(0); m_idx = 1; mo_n = 0; mo_bits = 0;
    end
    if (sclk_prev && !spi_sclk) begin
      if (m_bit == 3'd7) begin m_bit = 3'd0; miso_byte = get_b(m_idx); m_idx++; end
      else m_bit = m_bit + 3'd1;
    end
    if (!sclk_prev && spi_sclk) begin
      mo_sr = {mo_sr[6:0], spi_mosi}; mo_bits++;
      if (mo_bits == 8) begin
        if (mo_n < 64) begin mosi_log[mo_n] = mo_sr; cs_log[mo_n] = spi_cs_n; end
        mo_n++; mo_bits = 0;
      end
    end
    cs_prev = spi_cs_n; sclk_prev = spi_sclk;
  end
  assign spi_miso = miso_byte[3'd7 - m_bit];

  // ---------------- output monitor ----------------
  int done_cnt = 0, dv_n = 0;
  logic [7:0] dv_log [1024];
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (data_valid) begin dv_log[dv_n % 1024] = data_out; dv_n++; end
  end

  // ---------------- expectations ----------------
  logic [7:0] pl [NB];
  logic [7:0] exp_data [NB];
  logic [7:0] exp_mosi [64];
  logic [2:0] exp_status; logic [7:0] exp_r1; int exp_nd, exp_nbytes;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_pl();
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < NB; i++) begin
      c = c ^ {pl[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic build(input vec_t v, input bit rnd);
    int p; logic [15:0] c;
    logic [7:0] fixed [4];
    fixed[0] = 8'hDE; fixed[1] = 8'hAD; fixed[2] = 8'hBE; fixed[3] = 8'hEF;
    for (int i = 0; i < 64; i++) m_stream[i] = 8'hFF;
    p = 6;
    for (int i = 0; i < v.r1_dly; i++) begin
      m_stream[p] = rnd ? 8'($urandom_range(128, 255)) : 8'hFF; p++;
    end
    m_stream[p] = v.r1b; p++;
    for (int i = 0; i < v.tok_dly; i++) begin
      m_stream[p] = rnd ? 8'($urandom_range(16, 255)) : 8'hFF; p++;
    end
    m_stream[p] = v.tokb; p++;
    for (int i = 0; i < NB; i++) begin
      pl[i] = rnd ? 8'($urandom_range(0, 255)) : fixed[i % 4];
      m_stream[p] = pl[i]; p++;
    end
    c = crc_pl();
    if (v.crc_mode == 1) c = c ^ 16'h0001;
    m_stream[p] = c[15:8]; m_stream[p+1] = c[7:0];
  endtask

  task automatic set_mosi(input vec_t v);
    exp_mosi[0] = {2'b01, v.idx};
    exp_mosi[1] = v.arg[31:24]; exp_mosi[2] = v.arg[23:16];
    exp_mosi[3] = v.arg[15:8];  exp_mosi[4] = v.arg[7:0];
    exp_mosi[5] = {v.crc, 1'b1};
    for (int i = 6; i < 64; i++) exp_mosi[i] = 8'hFF;
  endtask

  // reference: walk the card's byte stream using the protocol rules
  task automatic model(input logic rd);
    int p; bit found, tok_ok; logic [7:0] b; logic [15:0] rc;
    p = 6; exp_status = 3'b000; exp_r1 = 8'hFF; exp_nd = 0; found = 0; tok_ok = 0;
    for (int k = 0; k < R1W && !found; k++) begin
      b = m_stream[p]; p++;
      if (!b[7]) begin found = 1; exp_r1 = b; end
    end
    if (!found) exp_status[0] = 1'b1;
    else if (exp_r1 == 8'h00 && rd) begin
      found = 0;
      for (int k = 0; k < TOKW && !found; k++) begin
        b = m_stream[p]; p++;
        if (b == 8'hFE) begin found = 1; tok_ok = 1; end
        else if (b[7:4] == 4'h0) found = 1;
      end
      if (!tok_ok) exp_status[1] = 1'b1;
      else begin
        for (int d = 0; d < NB; d++) begin exp_data[d] = m_stream[p]; p++; end
        rc = {m_stream[p], m_stream[p+1]}; p += 2;
        if (CRC_EN && rc != crc_pl()) exp_status[2] = 1'b1;
        exp_nd = NB;
      end
    end
    exp_nbytes = p - 6 + 7;
  endtask

  task automatic run(input vec_t v, input bit glitch);
    int base_done, base_dv, cyc, bad; bit seen; logic [2:0] st_done;
    @(negedge clk);
    cmd_index = v.idx; cmd_arg = v.arg; cmd_crc = v.crc; rd_data_en = v.rd;
    base_done = done_cnt; base_dv = dv_n;
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0; seen = 0; st_done = 3'b000;
    while (!seen && cyc < 6000) begin
      if (glitch && cyc == 60) begin start = 1'b1; cmd_index = ~v.idx; rd_data_en = ~v.rd; end
      else start = 1'b0;
      @(negedge clk); cyc++;
      if (done) begin seen = 1; st_done = status; end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt - base_done, 1);
    chk("status_at_done", st_done, exp_status);
    chk("status_hold", status, exp_status);
    chk("r1", r1, exp_r1);
    chk("busy_low", busy, 0);
    chk("cs_high", spi_cs_n, 1);
    chk("data_count", dv_n - base_dv, exp_nd);
    bad = 0;
    for (int i = 0; i < exp_nd && i < dv_n - base_dv; i++)
      if (dv_log[(base_dv + i) % 1024] !== exp_data[i]) bad++;
    chk("data_bytes_bad", bad, 0);
    chk("mosi_count", mo_n, exp_nbytes);
    bad = 0;
    for (int i = 0; i < exp_nbytes && i < mo_n && i < 64; i++)
      if (mosi_log[i] !== exp_mosi[i] || cs_log[i] !== (i == exp_nbytes - 1)) bad++;
    chk("mosi_bytes_bad", bad, 0);
  endtask

  task automatic run_dir(input vec_t v);
    build(v, 0); set_mosi(v);
    exp_status = v.exp_status; exp_r1 = v.exp_r1; exp_nd = v.exp_nd; exp_nbytes = v.exp_nbytes;
    for (int i = 0; i < NB; i++) exp_data[i] = pl[i];
    run(v, 0);
  endtask

  function automatic logic [63:0] outs();
    return {39'b0, busy, done, data_valid, status, r1, data_out, spi_sclk, spi_mosi, spi_cs_n};
  endfunction
  localparam logic [63:0] RST_V = {39'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1};

  vec_t vecs [9];

  initial begin
    vec_t v; int cyc, base_done;
    reset = 1'b1; start = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_crc = '0; rd_data_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), RST_V);
    reset = 1'b0;

    //         idx     arg           crc     rd    r1d r1b    tokd tokb   crcm  status                      r1     nd  nbytes
    vecs[0] = '{6'd0,  32'h00000000, 7'h4A, 1'b0, 1,  8'h01, 0,   8'hFE, 0,    3'b000,                     8'h01, 0,  9};
    vecs[1] = '{6'd17, 32'h00001000, 7'h2B, 1'b1, 0,  8'h00, 1,   8'hFE, 0,    3'b000,                     8'h00, 4,  16};
    vecs[2] = '{6'd17, 32'h00001000, 7'h2B, 1'b1, 0,  8'h00, 1,   8'hFE, 1,    (CRC_EN ? 3'b100 : 3'b000), 8'h00, 4,  16};
    vecs[3] = '{6'd8,  32'h000001AA, 7'h43, 1'b0, 20, 8'h01, 0,   8'hFE, 0,    3'b001,                     8'hFF, 0,  15};
    vecs[4] = '{6'd17, 32'h12345678, 7'h11, 1'b1, 0,  8'h00, 2,   8'h08, 0,    3'b010,                     8'h00, 0,  11};
    vecs[5] = '{6'd18, 32'hA5A5A5A5, 7'h7F, 1'b1, 0,  8'h00, 20,  8'hFE, 0,    3'b010,                     8'h00, 0,  24};
    vecs[6] = '{6'd17, 32'h00000200, 7'h05, 1'b1, 7,  8'h05, 0,   8'hFE, 0,    3'b000,                     8'h05, 0,  15};
    vecs[7] = '{6'd24, 32'hFFFFFFFF, 7'h3C, 1'b0, 0,  8'h00, 0,   8'hFE, 0,    3'b000,                     8'h00, 0,  8};
    vecs[8] = '{6'd55, 32'h00000000, 7'h32, 1'b0, 8,  8'h01, 0,   8'hFE, 0,    3'b001,                     8'hFF, 0,  15};

    for (int i = 0; i < 9; i++) begin
      run_dir(vecs[i]);
      if (i == 0) chk("cmd0_crc_byte", mosi_log[5], 8'h95);
    end

    // reset while payload is being received
    build(vecs[1], 0);
    @(negedge clk);
    cmd_index = vecs[1].idx; cmd_arg = vecs[1].arg; cmd_crc = vecs[1].crc; rd_data_en = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!data_valid && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("rst_mid_reached_data", data_valid, 1);
    base_done = done_cnt;
    reset = 1'b1; @(negedge clk);
    chk("rst_mid_outputs", outs(), RST_V);
    @(negedge clk); reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - base_done, 0);
    chk("rst_mid_idle", outs(), RST_V);
    run_dir(vecs[0]);

    // randomized transactions against the stream-walking model
    for (int n = 0; n < 25; n++) begin
      v.idx = 6'($urandom_range(0, 63)); v.arg = $urandom; v.crc = 7'($urandom_range(0, 127));
      v.rd = ($urandom_range(0, 3) != 0);
      v.r1_dly = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0, 1: v.r1b = 8'h00;
        2: v.r1b = 8'h01;
        default: v.r1b = 8'($urandom_range(0, 127));
      endcase
      v.tok_dly = $urandom_range(0, 18);
      v.tokb = ($urandom_range(0, 3) != 0) ? 8'hFE : 8'($urandom_range(0, 15));
      v.crc_mode = $urandom_range(0, 1);
      build(v, 1); set_mosi(v); model(v.rd);
      run(v, (n % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd_engine.md
SD_SPI_CMD_ENGINE -- requirements
Module: sd_spi_cmd_engine

Interface
REQ-001 Parameters SHALL be:
- DATA_BYTES, 512, data block payload length in bytes (1..4096).
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).
- R1_WAIT_MAX, 8, max poll bytes for the R1 response.
- TOKEN_WAIT_MAX, 1024, max poll bytes for the start token.

REQ-002 Ports SHALL be:
- clk, in, 1, sole clock; one clock; reset is synchronous and active-high.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, launch command; sampled only in IDLE.
- cmd_index, in, 6, command number; engine forms byte 0x40|cmd_index.
- cmd_arg, in, 32, argument, sent MSB first.
- cmd_crc, in, 7, CRC7; engine appends end bit 1.
- rd_data_en, in, 1, expect a data block after R1.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle completion pulse.
- status, out, 3, {crc_err, token_err, r1_timeout}, valid with done.
- r1, out, 8, captured R1 byte.
- data_out, out, 8, received payload byte.
- data_valid, out, 1, one-cycle strobe per payload byte.
- spi_sclk, out, 1, SPI clock, mode 0, idle low.
- spi_mosi, out, 1, SPI data out.
- spi_miso, in, 1, SPI data in.
- spi_cs_n, out, 1, chip select, active low.

Function
REQ-003 The FSM SHALL have states IDLE, SEND, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC, FINISH.
REQ-004 All bytes SHALL be shifted MSB first; mosi changes after the sclk falling edge; miso is sampled on the sclk rising edge; each sclk half-period lasts CLK_DIV clk cycles.
REQ-005 In IDLE, start=1 SHALL latch all inputs, set busy and spi_cs_n=0 on the next cycle, and enter SEND; start while busy SHALL be ignored.
REQ-006 SEND SHALL transmit 6 bytes: 0x40|cmd_index, cmd_arg[31:24..7:0], {cmd_crc,1'b1}.
REQ-007 WAIT_R1 SHALL clock out 0xFF bytes; the first received byte with bit7=0 SHALL be stored in r1; if R1_WAIT_MAX bytes pass without one, set r1_timeout and go to FINISH.
REQ-008 After R1: if r1!=0x00 or rd_data_en=0, go to FINISH; else go to WAIT_TOKEN.
REQ-009 WAIT_TOKEN SHALL poll 0xFF bytes: 0xFE -> READ_DATA; byte with upper nibble 0000 (data error token) -> set token_err, FINISH; TOKEN_WAIT_MAX bytes elapsed -> set token_err, FINISH.
REQ-010 READ_DATA SHALL present each of DATA_BYTES bytes on data_out with data_valid high exactly one clk, in arrival order, then enter READ_CRC.
REQ-011 READ_CRC SHALL receive 2 bytes (CRC16, MSB first), then enter FINISH.
REQ-012 FINISH SHALL clock one trailing 0xFF byte with spi_cs_n=1, then pulse done, drop busy and return to IDLE; status and r1 SHALL hold until the next accepted start.
REQ-013 Byte and poll counters SHALL be sized by $clog2 of their parameter and SHALL not wrap before their limit is detected.

Reset
REQ-014 While reset=1, at any state: state=IDLE, busy=0, done=0, data_valid=0, status=0, r1=0xFF, data_out=0x00, spi_sclk=0, spi_mosi=1, spi_cs_n=1.
REQ-015 Reset mid-transaction SHALL abort it without a done pulse.

Configuration
REQ-016 With SD_CMD_CRC16_CHECK_EN defined, a CRC16-CCITT (poly 0x1021, init 0x0000) SHALL be computed over the payload and compared with the received CRC; mismatch sets crc_err. Without it, the CRC bytes are received and discarded, and crc_err is always 0.

Verification
REQ-017 CMD0, arg 0, crc 0x4A, miso replies 0x01 on the 2nd poll byte -> mosi 40 00 00 00 00 95, r1=0x01, status=000, done once, no data_valid.
REQ-018 CMD17, rd_data_en=1, DATA_BYTES=4, R1 0x00, token 0xFE, data DE AD BE EF plus correct CRC -> 4 data_valid strobes DE,AD,BE,EF, status=000.
REQ-019 Same as REQ-018 with CRC byte corrupted -> status=100 with macro defined, 000 without.
REQ-020 miso held at 0xFF -> r1_timeout after exactly R1_WAIT_MAX poll bytes, status=001, spi_cs_n returns to 1.
REQ-021 Error token 0x08 during WAIT_TOKEN -> status=010, no data_valid; reset asserted during READ_DATA -> outputs at reset values, no done pulse.
